// File: rtl/mem_pkg.sv
// Shared FSM state type and default sizing for the data memory responder.
package mem_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCESS  = 2'd1,
        RESPOND = 2'd2
    } state_e;

    localparam int unsigned DEFAULT_DEPTH   = 256;
    localparam int unsigned DEFAULT_LATENCY = 2;
    localparam int unsigned LANE_WIDTH      = 8;

endpackage

// File: rtl/byte_lane_unit.sv
// Combinational byte-lane helper: sign-extending lane extract for loads and
// single-lane merge for stores (little-endian lane order).
module byte_lane_unit
    import mem_pkg::*;
(
    input  logic [31:0]           word,
    input  logic [1:0]            lane,
    input  logic [LANE_WIDTH-1:0] wbyte,
    output logic [31:0]           load_ext,
    output logic [31:0]           merged
);

    logic [LANE_WIDTH-1:0] lane_byte;

    always_comb begin
        lane_byte = word[lane*LANE_WIDTH +: LANE_WIDTH];
        load_ext  = {{(32-LANE_WIDTH){lane_byte[LANE_WIDTH-1]}}, lane_byte};
        merged    = word;
        merged[lane*LANE_WIDTH +: LANE_WIDTH] = wbyte;
    end

endmodule

// File: rtl/data_memory_responder.sv
// Word-addressed data memory behind a req/ready handshake with fixed access latency.
// Define BYTE_OPS_EN to add lb/sb support through byte_lane_unit.
module data_memory_responder
    import mem_pkg::*;
#(
    parameter int unsigned DEPTH   = DEFAULT_DEPTH,
    parameter int unsigned LATENCY = DEFAULT_LATENCY
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req,
    input  logic        we,
    input  logic        byte_op,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        ready,
    output logic        err
);

    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        fire;

    logic        we_q, byte_q;
    logic [31:0] addr_q, wdata_q;
    logic [31:0] rdata_q;
    logic        err_q;

    // Contents survive reset; only the power-up image is zero.
    logic [31:0] mem [DEPTH] = '{default: '0};

    logic             is_byte, acc_err;
    logic [IDX_W-1:0] idx;
    logic [31:0]      cur_word, load_val, store_val;

    assign idx      = addr_q[IDX_W+1:2];
    assign cur_word = mem[idx];
    assign acc_err  = (!is_byte && addr_q[1:0] != 2'b00) || ({2'b00, addr_q[31:2]} >= DEPTH);

`ifdef BYTE_OPS_EN
    logic [31:0] lane_load, lane_merge;

    assign is_byte = byte_q;

    byte_lane_unit u_lane (
        .word     (cur_word),
        .lane     (addr_q[1:0]),
        .wbyte    (wdata_q[LANE_WIDTH-1:0]),
        .load_ext (lane_load),
        .merged   (lane_merge)
    );

    assign load_val  = is_byte ? lane_load  : cur_word;
    assign store_val = is_byte ? lane_merge : wdata_q;
`else
    logic unused_byte;

    assign unused_byte = byte_q;
    assign is_byte     = 1'b0;
    assign load_val    = cur_word;
    assign store_val   = wdata_q;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        fire    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (req) begin
                    state_d = ACCESS;
                    cnt_d   = '0;
                end
            end
            ACCESS: begin
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == 4'(LATENCY - 1)) begin
                    fire    = 1'b1;
                    state_d = RESPOND;
                end
            end
            RESPOND: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            we_q    <= 1'b0;
            byte_q  <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            if (state_q == IDLE && req) begin
                we_q    <= we;
                byte_q  <= byte_op;
                addr_q  <= addr;
                wdata_q <= wdata;
            end
            if (fire) begin
                err_q   <= acc_err;
                rdata_q <= (acc_err || we_q) ? '0 : load_val;
            end
        end
    end

    // fire derives from the async-reset state, so an aborted access never writes.
    always_ff @(posedge clock) begin
        if (fire && we_q && !acc_err) begin
            mem[idx] <= store_val;
        end
    end

    assign ready = (state_q == RESPOND);
    assign rdata = ready ? rdata_q : '0;
    assign err   = ready & err_q;

endmodule

// File: tb/tb_data_memory_responder.sv
// Self-checking bench for data_memory_responder: spec vector table, hand-written
// multi-cycle sequences, then randomized transactions against a reference model.
module tb_data_memory_responder;

    localparam int unsigned DEPTH   = 256;
    localparam int unsigned LATENCY = 2;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        req = 1'b0, we = 1'b0, byte_op = 1'b0;
    logic [31:0] addr = '0, wdata = '0;
    logic [31:0] rdata;
    logic        ready, err;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    logic [31:0] model_mem [DEPTH];

    data_memory_responder #(.DEPTH(DEPTH), .LATENCY(LATENCY)) dut (
        .clock   (clock),
        .reset   (reset),
        .req     (req),
        .we      (we),
        .byte_op (byte_op),
        .addr    (addr),
        .wdata   (wdata),
        .rdata   (rdata),
        .ready   (ready),
        .err     (err)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
        end
    endtask

    // Reference behaviour computed directly from the access rules.
    function automatic void model(input logic m_we, input logic m_bo, input logic [31:0] a,
                                  input logic [31:0] wd, output logic [31:0] rd,
                                  output logic er);
        logic [29:0] widx;
        logic        is_byte;
        int unsigned sh;
        logic [7:0]  b;
        widx = a[31:2];
`ifdef BYTE_OPS_EN
        is_byte = m_bo;
`else
        is_byte = m_bo & 1'b0;
`endif
        sh = 8 * int'(a[1:0]);
        er = (!is_byte && a[1:0] != 2'b00) || (widx >= DEPTH);
        rd = '0;
        if (!er) begin
            if (m_we) begin
                if (is_byte)
                    model_mem[widx] = (model_mem[widx] & ~(32'hFF << sh)) | ({24'h0, wd[7:0]} << sh);
                else
                    model_mem[widx] = wd;
            end else if (is_byte) begin
                b  = 8'(model_mem[widx] >> sh);
                rd = 32'($signed(b));
            end else begin
                rd = model_mem[widx];
            end
        end
    endfunction

    // One handshake; operands are scrambled while the DUT is busy to prove they are ignored.
    task automatic run_txn(input logic t_we, input logic t_bo, input logic [31:0] t_addr,
                           input logic [31:0] t_wd, output logic [31:0] got_rd,
                           output logic got_err);
        int  lat;
        bit  seen, leak;
        @(negedge clock);
        req = 1'b1; we = t_we; byte_op = t_bo; addr = t_addr; wdata = t_wd;
        lat = 0; seen = 0; leak = 0; got_rd = '0; got_err = 1'b0;
        while (!seen && lat < 20) begin
            @(posedge clock); #1;
            lat++;
            if (ready) begin
                seen    = 1;
                got_rd  = rdata;
                got_err = err;
            end else begin
                if (rdata !== '0 || err !== 1'b0) leak = 1;
                @(negedge clock);
                we = 1'($urandom); byte_op = 1'($urandom); addr = $urandom; wdata = $urandom;
            end
        end
        @(negedge clock);
        req = 1'b0;
        check("ready_seen", 32'(seen), 32'd1);
        check("latency", 32'(lat), 32'(LATENCY + 1));
        check("idle_outputs_zero", 32'(leak), 32'd0);
        @(posedge clock); #1;
        check("ready_one_cycle", 32'(ready), 32'd0);
    endtask

    typedef struct {
        logic        we;
        logic        bo;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t vecs[14];

    initial begin
        logic [31:0] rd, mrd, rd2;
        logic        er, mer, er2;
        int          t1, t2, n;
        bit          pulse;

        for (int i = 0; i < int'(DEPTH); i++) model_mem[i] = '0;

        vecs[0]  = '{1'b1, 1'b0, 32'h10,  32'hDEADBEEF, 32'h0,        1'b0};
        vecs[1]  = '{1'b0, 1'b0, 32'h10,  32'h0,        32'hDEADBEEF, 1'b0};
        vecs[2]  = '{1'b0, 1'b0, 32'h3,   32'h0,        32'h0,        1'b1};
        vecs[3]  = '{1'b1, 1'b0, 32'h400, 32'hCAFEF00D, 32'h0,        1'b1};
        vecs[4]  = '{1'b0, 1'b0, 32'h0,   32'h0,        32'h0,        1'b0};
        vecs[5]  = '{1'b1, 1'b0, 32'h4,   32'h11223344, 32'h0,        1'b0};
        vecs[12] = '{1'b1, 1'b0, 32'h3FC, 32'h55AA55AA, 32'h0,        1'b0};
        vecs[13] = '{1'b0, 1'b0, 32'h3FC, 32'h0,        32'h55AA55AA, 1'b0};
`ifdef BYTE_OPS_EN
        vecs[6]  = '{1'b1, 1'b1, 32'h6,   32'h000000F0, 32'h0,        1'b0};
        vecs[7]  = '{1'b0, 1'b0, 32'h4,   32'h0,        32'h11F03344, 1'b0};
        vecs[8]  = '{1'b0, 1'b1, 32'h6,   32'h0,        32'hFFFFFFF0, 1'b0};
        vecs[9]  = '{1'b1, 1'b1, 32'h5,   32'h000000AB, 32'h0,        1'b0};
        vecs[10] = '{1'b0, 1'b0, 32'h4,   32'h0,        32'h11F0AB44, 1'b0};
        vecs[11] = '{1'b0, 1'b1, 32'h4,   32'h0,        32'h00000044, 1'b0};
`else
        vecs[6]  = '{1'b1, 1'b1, 32'h6,   32'h000000F0, 32'h0,        1'b1};
        vecs[7]  = '{1'b0, 1'b0, 32'h4,   32'h0,        32'h11223344, 1'b0};
        vecs[8]  = '{1'b0, 1'b1, 32'h6,   32'h0,        32'h0,        1'b1};
        vecs[9]  = '{1'b1, 1'b1, 32'h5,   32'h000000AB, 32'h0,        1'b1};
        vecs[10] = '{1'b0, 1'b0, 32'h4,   32'h0,        32'h11223344, 1'b0};
        vecs[11] = '{1'b0, 1'b1, 32'h4,   32'h0,        32'h11223344, 1'b0};
`endif

        // Reset state
        #1;
        check("reset_ready", 32'(ready), 32'd0);
        check("reset_rdata", rdata, 32'h0);
        check("reset_err", 32'(err), 32'd0);
        repeat (3) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;

        for (int i = 0; i < 14; i++) begin
            run_txn(vecs[i].we, vecs[i].bo, vecs[i].addr, vecs[i].wdata, rd, er);
            model(vecs[i].we, vecs[i].bo, vecs[i].addr, vecs[i].wdata, mrd, mer);
            check($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rdata);
            check($sformatf("vec%0d_err", i), 32'(er), 32'(vecs[i].exp_err));
        end

        // Reset in the second ACCESS cycle aborts the store.
        @(negedge clock);
        req = 1'b1; we = 1'b1; byte_op = 1'b0; addr = 32'h20; wdata = 32'h12345678;
        @(posedge clock);
        @(posedge clock);
        #2;
        reset = 1'b1; req = 1'b0;
        pulse = 0;
        repeat (3) begin
            @(posedge clock); #1;
            if (ready) pulse = 1;
        end
        @(negedge clock);
        reset = 1'b0;
        repeat (4) begin
            @(posedge clock); #1;
            if (ready) pulse = 1;
        end
        check("abort_no_ready", 32'(pulse), 32'd0);
        run_txn(1'b0, 1'b0, 32'h20, 32'h0, rd, er);
        check("abort_no_write", rd, 32'h0);

        // Reset must clear outputs asynchronously, mid-RESPOND.
        @(negedge clock);
        req = 1'b1; we = 1'b0; byte_op = 1'b0; addr = 32'h10;
        n = 0; pulse = 0;
        while (!pulse && n < 20) begin
            @(posedge clock); #1;
            n++;
            if (ready) pulse = 1;
        end
        check("async_pre_ready", 32'(pulse), 32'd1);
        check("async_pre_rdata", rdata, 32'hDEADBEEF);
        #2;
        reset = 1'b1; req = 1'b0;
        #1;
        check("async_ready", 32'(ready), 32'd0);
        check("async_rdata", rdata, 32'h0);
        @(negedge clock);
        reset = 1'b0;

        // Back-to-back: req held high across a store and a load.
        @(negedge clock);
        req = 1'b1; we = 1'b1; byte_op = 1'b0; addr = 32'h8; wdata = 32'hA5A50F0F;
        t1 = -1; t2 = -1; n = 0; rd2 = '0; er2 = 1'b0;
        while (t2 < 0 && n < 30) begin
            @(posedge clock); #1;
            n++;
            if (ready) begin
                if (t1 < 0) begin
                    t1 = cyc;
                    @(negedge clock);
                    we = 1'b0; wdata = $urandom;
                end else begin
                    t2 = cyc; rd2 = rdata; er2 = err;
                end
            end
        end
        @(negedge clock);
        req = 1'b0;
        model(1'b1, 1'b0, 32'h8, 32'hA5A50F0F, mrd, mer);
        check("b2b_both_pulses", 32'(t1 >= 0 && t2 >= 0), 32'd1);
        check("b2b_spacing", 32'(t2 - t1), 32'(LATENCY + 2));
        check("b2b_rdata", rd2, 32'hA5A50F0F);
        check("b2b_err", 32'(er2), 32'd0);

        // Randomized traffic against the model.
        for (int k = 0; k < 300; k++) begin
            logic        r_we, r_bo;
            logic [31:0] r_addr, r_wd;
            r_we = 1'($urandom);
            r_bo = 1'($urandom);
            r_wd = $urandom;
            case ($urandom_range(0, 9))
                0: r_addr = $urandom;
                1: r_addr = (DEPTH - 1 - $urandom_range(0, 3)) * 4 + $urandom_range(0, 3);
                2: r_addr = DEPTH * 4 + $urandom_range(0, 15);
                default: r_addr = $urandom_range(0, 15) * 4 +
                                  (($urandom_range(0, 2) == 0) ? $urandom_range(1, 3) : 0);
            endcase
            run_txn(r_we, r_bo, r_addr, r_wd, rd, er);
            model(r_we, r_bo, r_addr, r_wd, mrd, mer);
            check($sformatf("rand%0d_rdata a=%08h", k, r_addr), rd, mrd);
            check($sformatf("rand%0d_err a=%08h", k, r_addr), 32'(er), 32'(mer));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
